img2col_sipo_collector: RTL and testbench
=========================================

Name: img2col_sipo_collector

Overview:
- Upstream stage of the img2col PIPO register bank.
- Accepts a serial pixel stream, one element per cycle, on a valid/ready handshake and packs it into a reg_num-wide parallel vector.
- Presents each completed vector on a valid/ready output whose data width and shape match the PIPO bank's parallel input.
- Double-buffered: a collection buffer plus an output holding register, so filling continues while a finished vector waits to be taken.

Parameters:
data_width, 16, bits per pixel element
reg_num, 20, elements per output vector

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  upstream element valid
in_ready  out  1  collector can accept an element this cycle
in_data  in  data_width  pixel element
in_last  in  1  marks the final element of a segment; closes the vector early
out_valid  out  1  holding register contains a vector
out_ready  in  1  downstream takes the vector
out_data  out  data_width x reg_num (unpacked array [reg_num-1:0])  packed vector; index 0 is the first element received
out_count  out  $clog2(reg_num+1)  number of real elements in out_data (1..reg_num)
out_last  out  1  vector was closed by in_last

Behaviour:
- Reset:
  - While rst is high at a clk edge: out_valid=0, out_data all 0, out_count=0, out_last=0, write index=0, state=COLLECT.
  - in_ready=0 while rst is high.
  - Reset mid-fill discards the partial vector and any held vector.
- Accept and transfer:
  - An element is accepted when in_valid && in_ready at a clk edge; coll[idx] <= in_data and idx increments.
  - A vector completes on the accepted element where idx==reg_num-1 or in_last=1.
  - The holding register is free if out_valid=0, or if out_valid && out_ready in the same cycle.
- State COLLECT:
  - in_ready=1.
  - On completion with the holding register free: at the same edge hold <= completed vector (including the current element), out_valid<=1, out_count<=idx+1, out_last<=in_last, idx<=0. State stays COLLECT.
  - On completion with the holding register not free: go to WAIT. The completed vector stays in coll.
- State WAIT:
  - in_ready=0.
  - When out_valid && out_ready: at that edge transfer coll into hold, out_valid stays 1, idx<=0, state <= COLLECT.
- Padding:
  - On an early in_last, entries with index >= out_count are driven as 0 in the transferred vector.
  - Stale collection contents must never leak into padded entries.
- Output stability: while out_valid && !out_ready, out_data, out_count and out_last stay constant.
- Drain without refill: out_valid && out_ready with no transfer that edge -> out_valid<=0. out_data keeps its last value.
- Latency and throughput:
  - Completing element accepted at edge N with the holding register free -> out_valid=1 in cycle N+1.
  - Sustained 1 element/cycle with no bubble when out_ready=1.
- Corner cases:
  - in_last together with idx==reg_num-1 -> out_count=reg_num, out_last=1.
  - in_last on the first element -> out_count=1.
  - reg_num=1 is legal: every accepted element completes a vector.
- in_valid with in_ready=0 has no effect. Upstream holds its data.

Decomposition:
- img2col_pkg holds:
  - DATA_WIDTH default constant
  - state enum typedef {COLLECT, WAIT}
  - cnt_width(n) function returning $clog2(n+1)
- Single module; no sub-module is needed. The padding mask is a generate loop comparing index against the count.

Test Plan:
- Fill: push 1..20 with out_ready=1 -> out_valid high the cycle after the 20th accept; out_data[i]=i+1; out_count=20; out_last=0; in_ready never drops.
- Backpressure: out_ready=0, push 1..41 -> first vector held; 40th accept enters WAIT; in_ready=0 and 41 is not accepted. Pulse out_ready one cycle -> next cycle out_data[0]=21, then 41 is accepted.
- Early last: push 1..7 with in_last on 7 -> out_count=7; out_data[0..6]=1..7; out_data[7..19]=0 even after a previous full vector; out_last=1.
- Simultaneous drain and complete: out_valid=1, assert out_ready on the same cycle the 20th element of the next vector is accepted -> new vector appears next cycle with no WAIT and no bubble.
- Reset mid-fill: accept 10 elements, assert rst for 1 cycle -> out_valid=0, out_data=0. Then push 100..119 -> out_data[0]=100.
- Back-to-back early last: in_last on every element for 3 cycles -> three vectors, each out_count=1, out_data[0]=element, others 0.

Source files
------------

// File: rtl/img2col_pkg.sv
// Shared definitions for the img2col front end: the default pixel width,
// the collector state type and a helper that sizes element counters.
package img2col_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        WAIT    = 1'b1
    } state_t;

    // Bits needed to hold any count from 0 to n inclusive.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/img2col_sipo_collector.sv
// Serial-in parallel-out collector feeding the img2col PIPO register bank.
// Elements arrive one per cycle on a valid/ready handshake and are packed
// into a reg_num-wide vector. A collection buffer and an output holding
// register let filling continue while a finished vector waits downstream.
// Entries past the real element count of a vector are always presented as
// zero, so nothing left over from an earlier vector can leak through.
module img2col_sipo_collector
    import img2col_pkg::*;
#(
    parameter int data_width = DATA_WIDTH,
    parameter int reg_num    = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [data_width-1:0]           in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [data_width-1:0]           out_data [reg_num-1:0],
    output logic [cnt_width(reg_num)-1:0]   out_count,
    output logic                            out_last
);

    localparam int CW = cnt_width(reg_num);

    state_t                 state;
    logic [CW-1:0]          idx;
    logic [data_width-1:0]  coll [reg_num-1:0];
    logic [data_width-1:0]  hold [reg_num-1:0];
    logic [CW-1:0]          pend_count;
    logic                   pend_last;

    logic                   accept;
    logic                   complete;
    logic                   hold_free;
    logic                   load;
    logic [CW-1:0]          src_count;
    logic                   src_last;
    logic [data_width-1:0]  xfer_vec [reg_num-1:0];

    // Upstream may only push while collecting and out of reset.
    assign in_ready  = !rst && (state == COLLECT);
    assign accept    = in_valid && in_ready;
    assign complete  = accept && ((idx == CW'(reg_num - 1)) || in_last);
    assign hold_free = !out_valid || out_ready;

    // The holding register is refilled either straight from the stream or
    // from a vector that was parked in the collection buffer.
    assign load = (state == COLLECT) ? (complete && hold_free)
                                     : (out_valid && out_ready);

    // While collecting, the vector being closed includes the element on
    // the input this cycle; while waiting, it is the parked vector.
    assign src_count = (state == COLLECT) ? (idx + CW'(1)) : pend_count;
    assign src_last  = (state == COLLECT) ? in_last : pend_last;

    // Build the transfer vector, zeroing every entry at or beyond the count.
    for (genvar i = 0; i < reg_num; i++) begin : g_pad
        logic [data_width-1:0] src;
        assign src = ((state == COLLECT) && (idx == CW'(i))) ? in_data : coll[i];
        assign xfer_vec[i] = (CW'(i) < src_count) ? src : '0;
    end

    assign out_data = hold;

    // Collection buffer, write index, handshake state and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= COLLECT;
            idx        <= '0;
            out_valid  <= 1'b0;
            out_count  <= '0;
            out_last   <= 1'b0;
            pend_count <= '0;
            pend_last  <= 1'b0;
            for (int i = 0; i < reg_num; i++) begin
                coll[i] <= '0;
                hold[i] <= '0;
            end
        end else begin
            if (accept) begin
                coll[idx] <= in_data;
            end

            if (load) begin
                hold      <= xfer_vec;
                out_valid <= 1'b1;
                out_count <= src_count;
                out_last  <= src_last;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                COLLECT: begin
                    if (complete) begin
                        idx <= '0;
                        if (!hold_free) begin
                            state      <= WAIT;
                            pend_count <= idx + CW'(1);
                            pend_last  <= in_last;
                        end
                    end else if (accept) begin
                        idx <= idx + CW'(1);
                    end
                end
                WAIT: begin
                    if (out_valid && out_ready) begin
                        state <= COLLECT;
                        idx   <= '0;
                    end
                end
                default: begin
                    state <= COLLECT;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_img2col_sipo_collector.sv
// Directed testbench for img2col_sipo_collector with the default
// 16-bit x 20-element configuration. Inputs are driven and outputs are
// sampled 1 ns after each rising clock edge.
module tb_img2col_sipo_collector;

    localparam int DW = 16;
    localparam int RN = 20;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data [RN-1:0];
    logic [4:0]    out_count;
    logic          out_last;

    int checks = 0;
    int errors = 0;

    img2col_sipo_collector #(
        .data_width(DW),
        .reg_num   (RN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_last (out_last)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; in_valid = 1'b1; in_data = 16'd5; in_last = 1'b0; out_ready = 1'b0;
        cycle(); cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: actual=%b required=0", out_valid); end
        checks++; if (out_count !== 5'd0) begin errors++; $display("[TB] FAIL reset_count: actual=%0d required=0", out_count); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last: actual=%b required=0", out_last); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: actual=%b required=0", in_ready); end
        bad = 0;
        for (int i = 0; i < RN; i++) if (out_data[i] !== '0) bad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL reset_data: actual=%0d nonzero entries required=0", bad); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_ready: actual=%b required=1", in_ready); end
    endtask

    task automatic test_fill();
        int bad_ready, early, bad;
        bad_ready = 0; early = 0; bad = 0;
        out_ready = 1'b1;
        for (int k = 1; k <= RN; k++) begin
            in_valid = 1'b1; in_data = DW'(k); in_last = 1'b0;
            #1;
            if (in_ready !== 1'b1) bad_ready++;
            cycle();
            if (k < RN && out_valid !== 1'b0) early++;
        end
        in_valid = 1'b0;
        checks++; if (bad_ready != 0) begin errors++; $display("[TB] FAIL fill_in_ready: actual=%0d drops required=0", bad_ready); end
        checks++; if (early != 0) begin errors++; $display("[TB] FAIL fill_early_valid: actual=%0d required=0", early); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL fill_valid: actual=%b required=1", out_valid); end
        checks++; if (out_count !== 5'd20) begin errors++; $display("[TB] FAIL fill_count: actual=%0d required=20", out_count); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("[TB] FAIL fill_last: actual=%b required=0", out_last); end
        for (int i = 0; i < RN; i++) if (out_data[i] !== DW'(i + 1)) bad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL fill_data: actual=%0d wrong entries (data[0]=%0d) required=0", bad, out_data[0]); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL fill_drain: actual=%b required=0", out_valid); end
        checks++; if (out_data[0] !== 16'd1) begin errors++; $display("[TB] FAIL fill_data_kept: actual=%0d required=1", out_data[0]); end
    endtask

    task automatic test_backpressure();
        int bad_ready;
        bad_ready = 0;
        out_ready = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            in_valid = 1'b1; in_data = DW'(k); in_last = 1'b0;
            #1;
            if (in_ready !== 1'b1) bad_ready++;
            cycle();
        end
        checks++; if (bad_ready != 0) begin errors++; $display("[TB] FAIL bp_in_ready_fill: actual=%0d drops required=0", bad_ready); end
        in_data = 16'd41;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_wait_ready: actual=%b required=0", in_ready); end
        cycle();
        checks++; if (out_data[0] !== 16'd1 || out_count !== 5'd20) begin errors++; $display("[TB] FAIL bp_hold_stable: actual=%0d/%0d required=1/20", out_data[0], out_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_still_wait: actual=%b required=0", in_ready); end
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_refill_valid: actual=%b required=1", out_valid); end
        checks++; if (out_data[0] !== 16'd21 || out_data[19] !== 16'd40) begin errors++; $display("[TB] FAIL bp_refill_data: actual=%0d..%0d required=21..40", out_data[0], out_data[19]); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_resume_ready: actual=%b required=1", in_ready); end
        cycle();
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: actual=%b required=0", out_valid); end
        in_valid = 1'b1; in_data = 16'd99; in_last = 1'b1;
        cycle();
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_count !== 5'd2 || out_last !== 1'b1) begin errors++; $display("[TB] FAIL bp_41_count: actual=%0d last=%b required=2 last=1", out_count, out_last); end
        checks++; if (out_data[0] !== 16'd41 || out_data[1] !== 16'd99 || out_data[2] !== 16'd0) begin errors++; $display("[TB] FAIL bp_41_data: actual=%0d,%0d,%0d required=41,99,0", out_data[0], out_data[1], out_data[2]); end
        cycle();
    endtask

    task automatic test_early_last();
        int bad, badpad;
        bad = 0; badpad = 0;
        out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            in_valid = 1'b1; in_data = DW'(k); in_last = (k == 7);
            cycle();
        end
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_count !== 5'd7) begin errors++; $display("[TB] FAIL early_count: actual=%b/%0d required=1/7", out_valid, out_count); end
        checks++; if (out_last !== 1'b1) begin errors++; $display("[TB] FAIL early_last: actual=%b required=1", out_last); end
        for (int i = 0; i < 7; i++) if (out_data[i] !== DW'(i + 1)) bad++;
        for (int i = 7; i < RN; i++) if (out_data[i] !== '0) badpad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL early_data: actual=%0d wrong entries required=0", bad); end
        checks++; if (badpad != 0) begin errors++; $display("[TB] FAIL early_padding: actual=%0d nonzero pads (data[7]=%0d) required=0", badpad, out_data[7]); end
        cycle();
    endtask

    task automatic test_simultaneous();
        int bad_ready;
        bad_ready = 0;
        out_ready = 1'b0;
        for (int k = 1; k <= 39; k++) begin
            in_valid = 1'b1; in_last = 1'b0;
            in_data = (k <= 20) ? DW'(k) : DW'(k + 80);
            #1;
            if (in_ready !== 1'b1) bad_ready++;
            cycle();
        end
        in_data = 16'd120; out_ready = 1'b1;
        #1;
        if (in_ready !== 1'b1) bad_ready++;
        cycle();
        checks++; if (bad_ready != 0) begin errors++; $display("[TB] FAIL sim_in_ready: actual=%0d drops required=0", bad_ready); end
        checks++; if (out_valid !== 1'b1 || out_count !== 5'd20) begin errors++; $display("[TB] FAIL sim_valid: actual=%b/%0d required=1/20", out_valid, out_count); end
        checks++; if (out_data[0] !== 16'd101 || out_data[19] !== 16'd120) begin errors++; $display("[TB] FAIL sim_data: actual=%0d..%0d required=101..120", out_data[0], out_data[19]); end
        in_data = 16'd121;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL sim_no_bubble: actual=%b required=1", in_ready); end
        cycle();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL sim_drain: actual=%b required=0", out_valid); end
    endtask

    task automatic test_reset_midfill();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1; in_data = DW'(200 + k); in_last = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < RN; i++) if (out_data[i] !== '0) bad++;
        checks++; if (out_valid !== 1'b0 || out_count !== 5'd0) begin errors++; $display("[TB] FAIL midreset_state: actual=%b/%0d required=0/0", out_valid, out_count); end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL midreset_data: actual=%0d nonzero entries required=0", bad); end
        for (int k = 0; k < RN; k++) begin
            in_valid = 1'b1; in_data = DW'(100 + k); in_last = 1'b0;
            cycle();
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_count !== 5'd20) begin errors++; $display("[TB] FAIL midreset_refill: actual=%b/%0d required=1/20", out_valid, out_count); end
        checks++; if (out_data[0] !== 16'd100 || out_data[19] !== 16'd119) begin errors++; $display("[TB] FAIL midreset_refill_data: actual=%0d..%0d required=100..119", out_data[0], out_data[19]); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] elems [3];
        int bad;
        elems[0] = 16'd7; elems[1] = 16'd8; elems[2] = 16'd9;
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            in_valid = 1'b1; in_data = elems[n]; in_last = 1'b1;
            cycle();
            bad = 0;
            for (int i = 1; i < RN; i++) if (out_data[i] !== '0) bad++;
            checks++; if (out_valid !== 1'b1 || out_count !== 5'd1 || out_last !== 1'b1) begin errors++; $display("[TB] FAIL b2b_meta%0d: actual=%b/%0d/%b required=1/1/1", n, out_valid, out_count, out_last); end
            checks++; if (out_data[0] !== elems[n] || bad != 0) begin errors++; $display("[TB] FAIL b2b_data%0d: actual=%0d with %0d nonzero pads required=%0d with 0", n, out_data[0], bad, elems[n]); end
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        #2;
        test_reset();
        test_fill();
        test_backpressure();
        test_early_last();
        test_simultaneous();
        test_reset_midfill();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
